// File: rtl/mhd_pkg.sv
// Shared types for the Hamming-distance error monitor: FSM state encoding and
// the width helper used to size Hamming-distance values.
package mhd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits needed to hold a Hamming distance in 0..width.
  function automatic int hd_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hd_popcount.sv
// Combinational Hamming distance between two words: popcount(a XOR b).
module hd_popcount
  import mhd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]       a_i,
  input  logic [WIDTH-1:0]       b_i,
  output logic [hd_w(WIDTH)-1:0] hd_o
);

  localparam int HD_W = hd_w(WIDTH);

  logic [WIDTH-1:0] diff;

  // Count the differing bit positions.
  always_comb begin
    diff = a_i ^ b_i;
    hd_o = {HD_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      hd_o = hd_o + HD_W'(diff[i]);
    end
  end

endmodule

// File: rtl/mhd_err_monitor.sv
// Monitors a stream of exact/approximate word pairs, counting samples whose
// Hamming distance exceeds MHD through a two-stage pipeline under a run FSM.
module mhd_err_monitor
  import mhd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MHD   = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [hd_w(WIDTH)-1:0] max_hd,
  output logic [CNT_W-1:0]       first_viol_idx,
  output logic                   viol_seen
);

  localparam int HD_W = hd_w(WIDTH);
  localparam logic [HD_W-1:0] MHD_L = HD_W'(MHD);

  state_e           state_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] acc_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] err_q;
  logic [HD_W-1:0]  max_q;
  logic [CNT_W-1:0] first_q;
  logic             seen_q;

  logic             s1_valid_q;
  logic [HD_W-1:0]  s1_hd_q;
  logic [CNT_W-1:0] s1_idx_q;
  logic             s2_valid_q;
  logic             s2_viol_q;
  logic [HD_W-1:0]  s2_hd_q;
  logic [CNT_W-1:0] s2_idx_q;

  logic [HD_W-1:0]  hd_d;
  logic             abort_d;
  logic             accept_d;
  logic             last_d;

  hd_popcount #(.WIDTH(WIDTH)) u_hd_popcount (
    .a_i  (a),
    .b_i  (b),
    .hd_o (hd_d)
  );

  // An abort outranks acceptance, so a beat offered alongside it is dropped.
  always_comb begin
    abort_d  = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    accept_d = in_valid && ready_q && !abort_d;
    last_d   = (acc_q == (n_q - CNT_W'(1)));
  end

  // Stage 1 captures HD and index; stage 2 holds the threshold compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hd_q    <= {HD_W{1'b0}};
      s1_idx_q   <= {CNT_W{1'b0}};
      s2_valid_q <= 1'b0;
      s2_viol_q  <= 1'b0;
      s2_hd_q    <= {HD_W{1'b0}};
      s2_idx_q   <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= accept_d;
      if (accept_d) begin
        s1_hd_q  <= hd_d;
        s1_idx_q <= acc_q;
      end
      s2_valid_q <= s1_valid_q && !abort_d;
      s2_viol_q  <= (s1_hd_q > MHD_L);
      s2_hd_q    <= s1_hd_q;
      s2_idx_q   <= s1_idx_q;
    end
  end

  // Run FSM, accept counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= {CNT_W{1'b0}};
      acc_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= {CNT_W{1'b0}};
      max_q   <= {HD_W{1'b0}};
      first_q <= {CNT_W{1'b0}};
      seen_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (s2_valid_q && !abort_d) begin
        if (s2_viol_q) begin
          if (err_q != {CNT_W{1'b1}}) begin
            err_q <= err_q + CNT_W'(1);
          end
          if (!seen_q) begin
            seen_q  <= 1'b1;
            first_q <= s2_idx_q;
          end
        end
        if (s2_hd_q > max_q) begin
          max_q <= s2_hd_q;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q     <= num_samples;
            acc_q   <= {CNT_W{1'b0}};
            err_q   <= {CNT_W{1'b0}};
            max_q   <= {HD_W{1'b0}};
            first_q <= {CNT_W{1'b0}};
            seen_q  <= 1'b0;
            if (num_samples == {CNT_W{1'b0}}) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (accept_d) begin
            acc_q <= acc_q + CNT_W'(1);
            if (last_d) begin
              state_q <= ST_DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!s1_valid_q && !s2_valid_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_q;
  assign max_hd         = max_q;
  assign first_viol_idx = first_q;
  assign viol_seen      = seen_q;

endmodule

// File: tb/tb_mhd_err_monitor.sv
// Directed bench for mhd_err_monitor: default instance plus a CNT_W=4 instance
// for the narrow-counter run.
module tb_mhd_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, in_valid;
  logic [15:0] num_samples;
  logic [15:0] a, b;
  logic        in_ready, busy, done, viol_seen;
  logic [15:0] err_cnt, first_viol_idx;
  logic [4:0]  max_hd;

  logic        start4, abort4, in_valid4;
  logic [3:0]  num4;
  logic        in_ready4, busy4, done4, seen4;
  logic [3:0]  err4, first4;
  logic [4:0]  max4;

  int vectors = 0;
  int miscompares = 0;
  int acc_seen = 0;
  int done_seen = 0;

  mhd_err_monitor #(.WIDTH(16), .MHD(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .busy(busy), .done(done),
    .err_cnt(err_cnt), .max_hd(max_hd), .first_viol_idx(first_viol_idx), .viol_seen(viol_seen)
  );

  mhd_err_monitor #(.WIDTH(16), .MHD(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .num_samples(num4),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a), .b(b), .busy(busy4), .done(done4),
    .err_cnt(err4), .max_hd(max4), .first_viol_idx(first4), .viol_seen(seen4)
  );

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_seen++;
    if (done) done_seen++;
  end

  function automatic logic [15:0] ones(input int n);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    vectors++;
    if ({in_ready, busy, done, viol_seen, err_cnt, max_hd, first_viol_idx} !== 40'h0) begin
      $display("FAIL reset_async: got %h want 0", {in_ready, busy, done, viol_seen, err_cnt, max_hd, first_viol_idx});
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if ({in_ready, busy, done, viol_seen, err_cnt, max_hd, first_viol_idx, in_ready4, busy4, done4} !== 43'h0) begin
      $display("FAIL reset_held: got nonzero outputs");
      miscompares++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int hds[4];
    int lat;
    hds = '{0, 8, 9, 16};
    start = 1'b1; num_samples = 16'd4;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, in_ready} !== 2'b11) begin
      $display("FAIL basic_start: got busy/ready %b want 11", {busy, in_ready}); miscompares++;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'hA5A5;
      b = 16'hA5A5 ^ ones(hds[i]);
      if (i == 1) begin start = 1'b1; num_samples = 16'd1; end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    vectors++;
    if ({busy, in_ready} !== 2'b10) begin
      $display("FAIL basic_drain: got busy/ready %b want 10", {busy, in_ready}); miscompares++;
    end
    wait_done(lat);
    vectors++;
    if (lat !== 3) begin $display("FAIL basic_latency: got %0d want 3", lat); miscompares++; end
    vectors++;
    if (err_cnt !== 16'd2) begin $display("FAIL basic_err: got %0d want 2", err_cnt); miscompares++; end
    vectors++;
    if (max_hd !== 5'd16) begin $display("FAIL basic_max: got %0d want 16", max_hd); miscompares++; end
    vectors++;
    if (first_viol_idx !== 16'd2) begin $display("FAIL basic_first: got %0d want 2", first_viol_idx); miscompares++; end
    vectors++;
    if ({viol_seen, busy} !== 2'b10) begin $display("FAIL basic_seen_busy: got %b want 10", {viol_seen, busy}); miscompares++; end
    tick();
    vectors++;
    if ({done, err_cnt} !== {1'b0, 16'd2}) begin
      $display("FAIL basic_pulse_hold: got done=%b err=%0d want 0/2", done, err_cnt); miscompares++;
    end
  endtask

  task automatic test_toggle;
    int vals[5];
    int hds[3];
    int j;
    int lat;
    int base_acc;
    int base_done;
    vals = '{1, 0, 1, 0, 1};
    hds = '{5, 12, 10};
    j = 0;
    base_acc = acc_seen;
    base_done = done_seen;
    start = 1'b1; num_samples = 16'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = vals[i][0];
      a = 16'h0F0F;
      if (vals[i] == 1) begin
        b = 16'h0F0F ^ ones(hds[j]);
        j++;
      end else begin
        b = 16'h0F0F ^ ones(16);
      end
      tick();
    end
    vectors++;
    if (in_ready !== 1'b0) begin $display("FAIL toggle_ready: got %b want 0", in_ready); miscompares++; end
    b = 16'h0F0F ^ ones(16);
    wait_done(lat);
    in_valid = 1'b0;
    vectors++;
    if (lat !== 3) begin $display("FAIL toggle_latency: got %0d want 3", lat); miscompares++; end
    tick();
    tick();
    vectors++;
    if (acc_seen - base_acc !== 3) begin $display("FAIL toggle_accepts: got %0d want 3", acc_seen - base_acc); miscompares++; end
    vectors++;
    if (done_seen - base_done !== 1) begin $display("FAIL toggle_done_count: got %0d want 1", done_seen - base_done); miscompares++; end
    vectors++;
    if ({err_cnt, max_hd, first_viol_idx} !== {16'd2, 5'd12, 16'd1}) begin
      $display("FAIL toggle_results: got err=%0d max=%0d first=%0d want 2/12/1", err_cnt, max_hd, first_viol_idx); miscompares++;
    end
  endtask

  task automatic test_zero;
    start = 1'b1; num_samples = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, busy, in_ready} !== 3'b100) begin $display("FAIL zero_done: got done/busy/ready %b want 100", {done, busy, in_ready}); miscompares++; end
    vectors++;
    if ({err_cnt, viol_seen, max_hd} !== 22'h0) begin
      $display("FAIL zero_results: got err=%0d seen=%b max=%0d want 0/0/0", err_cnt, viol_seen, max_hd); miscompares++;
    end
    tick();
    vectors++;
    if ({done, busy} !== 2'b00) begin $display("FAIL zero_pulse: got done/busy %b want 00", {done, busy}); miscompares++; end
  endtask

  task automatic test_abort;
    int hds[5];
    int base_done;
    int lat;
    hds = '{16, 12, 3, 3, 3};
    start = 1'b1; num_samples = 16'd10;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 16'h3C3C;
      b = 16'h3C3C ^ ones(hds[i]);
      tick();
    end
    b = 16'h3C3C ^ ones(16);
    abort = 1'b1;
    base_done = done_seen;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if ({busy, in_ready} !== 2'b00) begin $display("FAIL abort_idle: got busy/ready %b want 00", {busy, in_ready}); miscompares++; end
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (done_seen - base_done !== 0) begin $display("FAIL abort_no_done: got %0d pulses want 0", done_seen - base_done); miscompares++; end
    vectors++;
    if ({err_cnt, max_hd, first_viol_idx, viol_seen} !== {16'd2, 5'd16, 16'd0, 1'b1}) begin
      $display("FAIL abort_partial: got err=%0d max=%0d first=%0d seen=%b want 2/16/0/1", err_cnt, max_hd, first_viol_idx, viol_seen); miscompares++;
    end
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0;
    vectors++;
    if ({err_cnt, max_hd, first_viol_idx, viol_seen} !== 38'h0) begin
      $display("FAIL abort_restart_clear: got err=%0d max=%0d seen=%b want 0", err_cnt, max_hd, viol_seen); miscompares++;
    end
    in_valid = 1'b1; b = a;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    vectors++;
    if (lat !== 3) begin $display("FAIL abort_restart_latency: got %0d want 3", lat); miscompares++; end
    vectors++;
    if ({err_cnt, viol_seen} !== 17'h0) begin $display("FAIL abort_restart_result: got err=%0d seen=%b want 0", err_cnt, viol_seen); miscompares++; end
  endtask

  task automatic test_sat;
    int lat;
    start4 = 1'b1; num4 = 4'd15;
    tick();
    start4 = 1'b0;
    a = 16'h1234; b = 16'h1234 ^ ones(16);
    in_valid4 = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if ({busy4, in_ready4} !== 2'b10) begin $display("FAIL sat_ready: got busy/ready %b want 10", {busy4, in_ready4}); miscompares++; end
    in_valid4 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done4) begin lat = c; break; end
    end
    vectors++;
    if (lat !== 3) begin $display("FAIL sat_latency: got %0d want 3", lat); miscompares++; end
    vectors++;
    if (err4 !== 4'd15) begin $display("FAIL sat_err: got %0d want 15", err4); miscompares++; end
    vectors++;
    if ({first4, max4, seen4} !== {4'd0, 5'd16, 1'b1}) begin
      $display("FAIL sat_first_max: got first=%0d max=%0d seen=%b want 0/16/1", first4, max4, seen4); miscompares++;
    end
  endtask

  task automatic test_rst_drain;
    int base_done;
    int lat;
    start = 1'b1; num_samples = 16'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = 16'h5555; b = 16'h5555 ^ ones(16);
    tick();
    tick();
    in_valid = 1'b0;
    base_done = done_seen;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, busy, done, viol_seen, err_cnt, max_hd, first_viol_idx} !== 40'h0) begin
      $display("FAIL rst_drain_async: got %h want 0", {in_ready, busy, done, viol_seen, err_cnt, max_hd, first_viol_idx}); miscompares++;
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (done_seen - base_done !== 0) begin $display("FAIL rst_drain_no_done: got %0d pulses want 0", done_seen - base_done); miscompares++; end
    vectors++;
    if ({busy, err_cnt, viol_seen} !== 18'h0) begin $display("FAIL rst_drain_idle: got busy=%b err=%0d want 0", busy, err_cnt); miscompares++; end
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; b = 16'h5555 ^ ones(9);
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    vectors++;
    if (lat !== 3) begin $display("FAIL rst_next_latency: got %0d want 3", lat); miscompares++; end
    vectors++;
    if ({err_cnt, max_hd, first_viol_idx, viol_seen} !== {16'd1, 5'd9, 16'd0, 1'b1}) begin
      $display("FAIL rst_next_results: got err=%0d max=%0d first=%0d seen=%b want 1/9/0/1", err_cnt, max_hd, first_viol_idx, viol_seen); miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; num_samples = 16'd0;
    a = 16'h0000; b = 16'h0000;
    start4 = 1'b0; abort4 = 1'b0; in_valid4 = 1'b0; num4 = 4'd0;
    test_reset();
    test_basic();
    test_toggle();
    test_zero();
    test_abort();
    test_sat();
    test_rst_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mhd_err_monitor.md
MHD_ERR_MONITOR -- requirements
Module: mhd_err_monitor

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits.
REQ-002 Parameter MHD, default 8: Hamming-distance threshold; a sample violates when its HD > MHD.
REQ-003 Parameter CNT_W, default 16: width of sample and error counters.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin a run; sampled only in IDLE.
REQ-007 abort  in  1  terminate the current run; sampled in RUN and DRAIN.
REQ-008 num_samples  in  CNT_W  sample count N, latched on start.
REQ-009 in_valid  in  1  sample pair a/b is valid.
REQ-010 in_ready  out  1  monitor accepts a sample this cycle.
REQ-011 a, b  in  WIDTH  exact and approximate output words.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  one-cycle pulse at run completion.
REQ-014 err_cnt  out  CNT_W  number of violating samples.
REQ-015 max_hd  out  HD_W  largest HD seen in the run; HD_W = clog2(WIDTH+1).
REQ-016 first_viol_idx  out  CNT_W  zero-based index of the first violating sample; valid when viol_seen=1.
REQ-017 viol_seen  out  1  at least one violation in the run.

Function
REQ-018 States are IDLE, RUN, DRAIN, DONE; the FSM SHALL leave reset in IDLE.
REQ-019 IDLE: start=1 with N>0 SHALL latch N, clear err_cnt/max_hd/first_viol_idx/viol_seen and the accept counter, and enter RUN; start=1 with N=0 SHALL clear the results and enter DONE.
REQ-020 in_ready SHALL be 1 only in RUN with accept count < N; a beat is accepted when in_valid and in_ready are both 1, and it increments the accept counter.
REQ-021 Stage 1 SHALL register HD = popcount(a XOR b) and a valid bit and the sample index; stage 2 SHALL compare the registered HD against MHD and update results, giving 2-cycle latency from acceptance to the result update.
REQ-022 Stage 2 on valid: if HD > MHD, increment err_cnt (saturating at 2^CNT_W-1); if also viol_seen=0, set viol_seen and record the index; max_hd = max(max_hd, HD).
REQ-023 HD = MHD SHALL NOT count as a violation.
REQ-024 RUN SHALL go to DRAIN on the cycle the Nth beat is accepted; DRAIN SHALL go to DONE once both pipeline stages are empty.
REQ-025 DONE SHALL assert done for exactly one cycle and return to IDLE; results SHALL hold until the next start.
REQ-026 start in any state other than IDLE SHALL be ignored.
REQ-027 abort in RUN or DRAIN SHALL flush both pipeline valids and return to IDLE on the next edge, with no done pulse; partial results SHALL be held. abort SHALL take priority over acceptance in the same cycle.
REQ-028 in_valid with in_ready=0 SHALL have no effect; a/b SHALL be don't-care when in_valid=0.

Reset
REQ-029 rst SHALL force IDLE, clear the pipeline valids, and set in_ready, busy, done, err_cnt, max_hd, first_viol_idx and viol_seen to 0 immediately, independent of clk.
REQ-030 rst asserted mid-run SHALL discard the run entirely; the first start after deassertion SHALL begin a clean run.

Structure
REQ-031 Package mhd_pkg SHALL hold the state enum type and the HD_W width helper.
REQ-032 Sub-module hd_popcount (combinational XOR plus popcount, parameter WIDTH) SHALL compute HD; the FSM, counters and pipeline SHALL reside in mhd_err_monitor.

Verification
REQ-033 N=4, pairs with HD {0,8,9,16}, in_valid held high -> err_cnt=2, max_hd=16, first_viol_idx=2, viol_seen=1; done appears 3 cycles after the 4th acceptance.
REQ-034 N=3, in_valid toggled 1,0,1,0,1 -> exactly 3 beats accepted, in_ready=0 after the 3rd, and done is a single pulse.
REQ-035 start with N=0 -> done pulses the next cycle, err_cnt=0, viol_seen=0, busy stays 0.
REQ-036 N=10, abort asserted after 5 acceptances -> IDLE, no done pulse, results reflect only the beats already in the pipeline, and a subsequent start clears them.
REQ-037 CNT_W=4, N=15, every sample HD=16 -> err_cnt=15 with no wrap; first_viol_idx=0.
REQ-038 rst pulsed mid-DRAIN -> all outputs 0 asynchronously, no done pulse, and the next run is unaffected.
